// File: rtl/noc_flit_ejector_if.sv
// Link bundle for the flit ejector: credit-based flit input on one side,
// AXI-Stream master output on the other, plus the sticky overflow flag.
interface noc_flit_ejector_if #(
    parameter int TDATA_WIDTH          = 128,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 4,
    parameter int SERIALIZATION_FACTOR = 1
);
    localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int DEST_WIDTH = TDEST_WIDTH + TID_WIDTH;

    logic [FLIT_WIDTH-1:0]  data_in;
    logic [DEST_WIDTH-1:0]  dest_in;
    logic                   is_tail_in;
    logic                   send_in;
    logic                   credit_out;
    logic                   axis_out_tvalid;
    logic                   axis_out_tready;
    logic [TDATA_WIDTH-1:0] axis_out_tdata;
    logic                   axis_out_tlast;
    logic [TID_WIDTH-1:0]   axis_out_tid;
    logic [TDEST_WIDTH-1:0] axis_out_tdest;
    logic                   overflow_err;

    // Ejector side: consumes flits, drives the stream.
    modport slave (
        input  data_in, dest_in, is_tail_in, send_in, axis_out_tready,
        output credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast,
        output axis_out_tid, axis_out_tdest, overflow_err
    );

    // Environment side: router link sender and stream sink.
    modport master (
        output data_in, dest_in, is_tail_in, send_in, axis_out_tready,
        input  credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast,
        input  axis_out_tid, axis_out_tdest, overflow_err
    );
endinterface

// File: rtl/noc_flit_ejector.sv
// Receive-side termination of a credit-based NoC link. Flits land in a small
// FIFO, are reassembled SERIALIZATION_FACTOR at a time into one AXIS beat, and
// every popped flit returns one credit to the sender a cycle later.
module noc_flit_ejector #(
    parameter int TDATA_WIDTH          = 128,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 4,
    parameter int SERIALIZATION_FACTOR = 1,
    parameter int FLIT_BUFFER_DEPTH    = 2
) (
    input logic              clk,
    input logic              rst,
    noc_flit_ejector_if.slave lnk
);
    localparam int SF         = SERIALIZATION_FACTOR;
    localparam int DEPTH      = FLIT_BUFFER_DEPTH;
    localparam int FLIT_WIDTH = TDATA_WIDTH / SF;
    localparam int DEST_WIDTH = TDEST_WIDTH + TID_WIDTH;
    localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W      = $clog2(DEPTH + 1);
    localparam int CNT_W      = (SF > 1) ? $clog2(SF) : 1;

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  tail;
    } flit_t;

    flit_t            mem [DEPTH];
    flit_t            head;
    flit_t            flit_in;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             full, empty, push, pop;

    logic [CNT_W-1:0]       cnt;
    logic [TDATA_WIDTH-1:0] asm_data, word_next;
    logic [DEST_WIDTH-1:0]  asm_dest, dest_next;
    logic                   completing, out_free;

    logic                   tvalid_r, tlast_r, credit_r, overflow_r;
    logic [TDATA_WIDTH-1:0] tdata_r;
    logic [DEST_WIDTH-1:0]  tdest_r;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign flit_in = '{data: lnk.data_in, dest: lnk.dest_in, tail: lnk.is_tail_in};
    assign head    = mem[rd_ptr];
    assign full    = (occ == OCC_W'(DEPTH));
    assign empty   = (occ == '0);

    // A flit closes the word on the last slice or on an early tail. Only a
    // closing flit needs room in the output register; partial flits may pop
    // into the assembly register even while a finished beat waits for tready.
    assign completing = (cnt == CNT_W'(SF - 1)) || head.tail;
    assign out_free   = !tvalid_r || lnk.axis_out_tready;
    assign pop        = !empty && (!completing || out_free);
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign push       = lnk.send_in && (!full || pop);

    // Assembly view after writing the head flit into slice cnt; slice 0
    // starts a fresh word so stale upper slices never leak into a short beat.
    always_comb begin
        word_next = (cnt == '0) ? '0 : asm_data;
        word_next[cnt*FLIT_WIDTH +: FLIT_WIDTH] = head.data;
        dest_next = (cnt == '0) ? head.dest : asm_dest;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      occ <= occ + OCC_W'(1);
            else if (!push && pop) occ <= occ - OCC_W'(1);
        end
    end

    // FIFO storage; contents are qualified by occupancy so no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= flit_in;
    end

    // Slice counter and partial-word assembly register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            asm_data <= '0;
            asm_dest <= '0;
        end else if (pop) begin
            if (completing) begin
                cnt <= '0;
            end else begin
                cnt      <= cnt + 1'b1;
                asm_data <= word_next;
                asm_dest <= dest_next;
            end
        end
    end

    // Output register: loads a finished word, otherwise holds until tready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tvalid_r <= 1'b0;
            tdata_r  <= '0;
            tlast_r  <= 1'b0;
            tdest_r  <= '0;
        end else if (pop && completing) begin
            tvalid_r <= 1'b1;
            tdata_r  <= word_next;
            tlast_r  <= head.tail;
            tdest_r  <= dest_next;
        end else if (lnk.axis_out_tready) begin
            tvalid_r <= 1'b0;
        end
    end

    // Credit return one cycle after each pop; sticky overflow on a dropped flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            credit_r <= pop;
            if (lnk.send_in && full && !pop) overflow_r <= 1'b1;
        end
    end

    assign lnk.credit_out      = credit_r;
    assign lnk.axis_out_tvalid = tvalid_r;
    assign lnk.axis_out_tdata  = tdata_r;
    assign lnk.axis_out_tlast  = tlast_r;
    assign lnk.axis_out_tid    = tdest_r[DEST_WIDTH-1:TDEST_WIDTH];
    assign lnk.axis_out_tdest  = tdest_r[TDEST_WIDTH-1:0];
    assign lnk.overflow_err    = overflow_r;
endmodule

// File: tb/tb_noc_flit_ejector.sv
// Directed bench: dut_a runs SF=1, dut_b runs SF=4 (32-bit flits), both with
// a 2-deep flit buffer and 128-bit AXIS.
module tb_noc_flit_ejector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cred_a = 0;
    int   cred_b = 0;

    always #5 clk = ~clk;

    noc_flit_ejector_if #(.TDATA_WIDTH(128), .TID_WIDTH(2), .TDEST_WIDTH(4),
                          .SERIALIZATION_FACTOR(1)) ia ();
    noc_flit_ejector_if #(.TDATA_WIDTH(128), .TID_WIDTH(2), .TDEST_WIDTH(4),
                          .SERIALIZATION_FACTOR(4)) ib ();

    noc_flit_ejector #(.TDATA_WIDTH(128), .TID_WIDTH(2), .TDEST_WIDTH(4),
                       .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(2))
        dut_a (.clk(clk), .rst(rst), .lnk(ia));
    noc_flit_ejector #(.TDATA_WIDTH(128), .TID_WIDTH(2), .TDEST_WIDTH(4),
                       .SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(2))
        dut_b (.clk(clk), .rst(rst), .lnk(ib));

    // Advance one clock and sample 1ns later; credit pulses are tallied here.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ia.credit_out) cred_a++;
        if (ib.credit_out) cred_b++;
    endtask

    task automatic idle_inputs();
        ia.send_in = 0; ia.data_in = '0; ia.dest_in = '0; ia.is_tail_in = 0;
        ib.send_in = 0; ib.data_in = '0; ib.dest_in = '0; ib.is_tail_in = 0;
        ia.axis_out_tready = 1; ib.axis_out_tready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        cred_a = 0;
        cred_b = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ia.axis_out_tvalid, ia.axis_out_tlast, ia.axis_out_tid, ia.axis_out_tdest,
             ia.credit_out, ia.overflow_err} !== 10'd0) begin
            errors++; $display("FAIL reset_ctrl_a got %h exp 0", {ia.axis_out_tvalid,
                ia.axis_out_tlast, ia.axis_out_tid, ia.axis_out_tdest, ia.credit_out, ia.overflow_err});
        end
        checks++;
        if (ia.axis_out_tdata !== 128'h0) begin
            errors++; $display("FAIL reset_tdata_a got %h exp 0", ia.axis_out_tdata);
        end
        checks++;
        if ({ib.axis_out_tvalid, ib.axis_out_tlast, ib.axis_out_tid, ib.axis_out_tdest,
             ib.credit_out, ib.overflow_err} !== 10'd0) begin
            errors++; $display("FAIL reset_ctrl_b got %h exp 0", {ib.axis_out_tvalid,
                ib.axis_out_tlast, ib.axis_out_tid, ib.axis_out_tdest, ib.credit_out, ib.overflow_err});
        end
        rst = 0;
        cred_a = 0;
        cred_b = 0;
    endtask

    // SF=1 single flit: tvalid and credit two cycles after the send cycle.
    task automatic test_single();
        do_reset();
        ia.send_in = 1; ia.data_in = {16{8'hA5}}; ia.dest_in = 6'b10_0011; ia.is_tail_in = 1;
        tick();
        ia.send_in = 0;
        checks++;
        if (ia.axis_out_tvalid !== 1'b0) begin
            errors++; $display("FAIL single_early_tvalid got %b exp 0", ia.axis_out_tvalid);
        end
        tick();
        checks++;
        if (ia.axis_out_tvalid !== 1'b1 || ia.credit_out !== 1'b1) begin
            errors++; $display("FAIL single_latency got tvalid=%b credit=%b exp 1 1",
                               ia.axis_out_tvalid, ia.credit_out);
        end
        checks++;
        if (ia.axis_out_tdata !== {16{8'hA5}}) begin
            errors++; $display("FAIL single_tdata got %h exp %h", ia.axis_out_tdata, {16{8'hA5}});
        end
        checks++;
        if ({ia.axis_out_tid, ia.axis_out_tdest, ia.axis_out_tlast} !== 7'b10_0011_1) begin
            errors++; $display("FAIL single_side got %b exp 1000111",
                               {ia.axis_out_tid, ia.axis_out_tdest, ia.axis_out_tlast});
        end
        tick();
        checks++;
        if (ia.axis_out_tvalid !== 1'b0 || ia.credit_out !== 1'b0 || cred_a != 1) begin
            errors++; $display("FAIL single_drain got tvalid=%b credit=%b credits=%0d exp 0 0 1",
                               ia.axis_out_tvalid, ia.credit_out, cred_a);
        end
    endtask

    // SF=4 full beats: one with tail on the fourth flit, one without any tail.
    task automatic test_sf4_full();
        int n;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                ib.send_in    = 1;
                ib.data_in    = 32'(32'h11111111 * (i + 1));
                ib.dest_in    = (i == 0) ? 6'b01_0101 : 6'b11_1111;
                ib.is_tail_in = (p == 0) && (i == 3);
                tick();
            end
            ib.send_in = 0;
            n = 0;
            while (!ib.axis_out_tvalid && n < 20) begin tick(); n++; end
            checks++;
            if (ib.axis_out_tvalid !== 1'b1) begin
                errors++; $display("FAIL sf4_full_timeout got tvalid=%b exp 1", ib.axis_out_tvalid);
            end
            checks++;
            if (ib.axis_out_tdata !== 128'h44444444_33333333_22222222_11111111) begin
                errors++; $display("FAIL sf4_full_tdata got %h exp %h", ib.axis_out_tdata,
                                   128'h44444444_33333333_22222222_11111111);
            end
            checks++;
            if ({ib.axis_out_tid, ib.axis_out_tdest, ib.axis_out_tlast} !== {6'b01_0101, (p == 0)}) begin
                errors++; $display("FAIL sf4_full_side got %b exp %b",
                    {ib.axis_out_tid, ib.axis_out_tdest, ib.axis_out_tlast}, {6'b01_0101, (p == 0)});
            end
            repeat (3) tick();
        end
        checks++;
        if (cred_b != 8) begin
            errors++; $display("FAIL sf4_full_credits got %0d exp 8", cred_b);
        end
    endtask

    // SF=4 early tail, then a one-flit packet that must start at slice 0.
    task automatic test_sf4_early();
        int n;
        do_reset();
        ib.send_in = 1; ib.data_in = 32'hAAAAAAAA; ib.dest_in = 6'b10_0110; ib.is_tail_in = 0;
        tick();
        ib.data_in = 32'hBBBBBBBB; ib.dest_in = 6'b00_1111; ib.is_tail_in = 1;
        tick();
        ib.send_in = 0;
        n = 0;
        while (!ib.axis_out_tvalid && n < 20) begin tick(); n++; end
        checks++;
        if (ib.axis_out_tdata !== 128'h00000000_00000000_BBBBBBBB_AAAAAAAA) begin
            errors++; $display("FAIL sf4_early_tdata got %h exp %h", ib.axis_out_tdata,
                               128'h00000000_00000000_BBBBBBBB_AAAAAAAA);
        end
        checks++;
        if ({ib.axis_out_tvalid, ib.axis_out_tid, ib.axis_out_tdest, ib.axis_out_tlast} !== 8'b1_10_0110_1) begin
            errors++; $display("FAIL sf4_early_side got %b exp 11001101",
                {ib.axis_out_tvalid, ib.axis_out_tid, ib.axis_out_tdest, ib.axis_out_tlast});
        end
        ib.send_in = 1; ib.data_in = 32'hCCCCCCCC; ib.dest_in = 6'b00_0001; ib.is_tail_in = 1;
        tick();
        ib.send_in = 0;
        n = 0;
        while (!ib.axis_out_tvalid && n < 20) begin tick(); n++; end
        checks++;
        if (ib.axis_out_tvalid !== 1'b1 || ib.axis_out_tdata !== 128'h0000_0000_0000_0000_0000_0000_CCCC_CCCC) begin
            errors++; $display("FAIL sf4_next_pkt got v=%b %h exp 1 %h", ib.axis_out_tvalid,
                               ib.axis_out_tdata, 128'hCCCCCCCC);
        end
        checks++;
        if ({ib.axis_out_tdest, ib.axis_out_tlast} !== 5'b0001_1) begin
            errors++; $display("FAIL sf4_next_side got %b exp 00011", {ib.axis_out_tdest, ib.axis_out_tlast});
        end
        tick();
    endtask

    // SF=1 with tready=0: first flit parks in the output register (one credit),
    // the next two fill the FIFO, a fourth is dropped and flags overflow.
    task automatic test_backpressure();
        int nb;
        do_reset();
        ia.axis_out_tready = 0;
        for (int i = 1; i <= 3; i++) begin
            ia.send_in = 1; ia.data_in = 128'(i); ia.dest_in = '0; ia.is_tail_in = 1;
            tick();
        end
        checks++;
        if (ia.overflow_err !== 1'b0) begin
            errors++; $display("FAIL bp_no_overflow got %b exp 0", ia.overflow_err);
        end
        ia.data_in = 128'd4;
        tick();
        ia.send_in = 0;
        checks++;
        if (ia.overflow_err !== 1'b1) begin
            errors++; $display("FAIL bp_overflow got %b exp 1", ia.overflow_err);
        end
        repeat (2) tick();
        checks++;
        if (cred_a != 1 || ia.axis_out_tvalid !== 1'b1 || ia.axis_out_tdata !== 128'd1) begin
            errors++; $display("FAIL bp_held got credits=%0d v=%b d=%h exp 1 1 1",
                               cred_a, ia.axis_out_tvalid, ia.axis_out_tdata);
        end
        ia.axis_out_tready = 1;
        nb = 0;
        for (int c = 0; c < 20; c++) begin
            if (ia.axis_out_tvalid) begin
                checks++;
                if (ia.axis_out_tdata !== 128'(nb + 1)) begin
                    errors++; $display("FAIL bp_order got %h exp %h", ia.axis_out_tdata, 128'(nb + 1));
                end
                nb++;
            end
            tick();
        end
        checks++;
        if (nb != 3 || cred_a != 3 || ia.overflow_err !== 1'b1) begin
            errors++; $display("FAIL bp_totals got beats=%0d credits=%0d ovf=%b exp 3 3 1",
                               nb, cred_a, ia.overflow_err);
        end
    endtask

    // SF=1 credit-paced sender against a tready toggling every cycle.
    task automatic test_back_to_back();
        int tx, rx;
        logic [127:0] prev;
        logic prev_stall;
        do_reset();
        tx = 0; rx = 0; prev = '0; prev_stall = 0;
        for (int cyc = 0; cyc < 200 && rx < 8; cyc++) begin
            ia.axis_out_tready = (cyc % 2 == 0);
            if (prev_stall) begin
                checks++;
                if (ia.axis_out_tvalid !== 1'b1 || ia.axis_out_tdata !== prev) begin
                    errors++; $display("FAIL b2b_stable got v=%b %h exp 1 %h",
                                       ia.axis_out_tvalid, ia.axis_out_tdata, prev);
                end
            end
            if (ia.axis_out_tvalid && ia.axis_out_tready) begin
                checks++;
                if (ia.axis_out_tdata !== 128'h100 + 128'(rx)) begin
                    errors++; $display("FAIL b2b_order got %h exp %h", ia.axis_out_tdata,
                                       128'h100 + 128'(rx));
                end
                rx++;
            end
            prev_stall = ia.axis_out_tvalid && !ia.axis_out_tready;
            prev = ia.axis_out_tdata;
            if (tx < 8 && (tx - cred_a) < 2) begin
                ia.send_in = 1; ia.data_in = 128'h100 + 128'(tx); ia.is_tail_in = 1;
                tx++;
            end else begin
                ia.send_in = 0;
            end
            tick();
        end
        ia.send_in = 0;
        repeat (3) tick();
        checks++;
        if (rx != 8 || cred_a != 8 || ia.overflow_err !== 1'b0) begin
            errors++; $display("FAIL b2b_totals got rx=%0d credits=%0d ovf=%b exp 8 8 0",
                               rx, cred_a, ia.overflow_err);
        end
    endtask

    // Reset mid-packet on SF=4: outputs clear immediately, next packet is clean.
    task automatic test_reset_mid();
        int n;
        do_reset();
        ib.axis_out_tready = 0;
        for (int i = 0; i < 6; i++) begin
            ib.send_in = 1; ib.data_in = 32'(i + 1); ib.dest_in = 6'b11_0010;
            ib.is_tail_in = (i == 3);
            tick();
        end
        ib.send_in = 0;
        repeat (2) tick();
        checks++;
        if (ib.axis_out_tvalid !== 1'b1) begin
            errors++; $display("FAIL rmid_pre got tvalid=%b exp 1", ib.axis_out_tvalid);
        end
        rst = 1;
        #1;
        checks++;
        if ({ib.axis_out_tvalid, ib.axis_out_tlast, ib.axis_out_tid, ib.axis_out_tdest,
             ib.credit_out, ib.overflow_err} !== 10'd0 || ib.axis_out_tdata !== 128'h0) begin
            errors++; $display("FAIL rmid_async got v=%b d=%h exp 0 0", ib.axis_out_tvalid, ib.axis_out_tdata);
        end
        @(posedge clk);
        #1;
        rst = 0; cred_b = 0;
        ib.axis_out_tready = 1;
        for (int i = 0; i < 4; i++) begin
            ib.send_in = 1; ib.data_in = 32'hA0000001 + 32'(i);
            ib.dest_in = (i == 0) ? 6'b01_1000 : 6'b00_0000; ib.is_tail_in = (i == 3);
            tick();
        end
        ib.send_in = 0;
        n = 0;
        while (!ib.axis_out_tvalid && n < 20) begin tick(); n++; end
        checks++;
        if (ib.axis_out_tvalid !== 1'b1 || ib.axis_out_tdata !== 128'hA0000004_A0000003_A0000002_A0000001) begin
            errors++; $display("FAIL rmid_fresh got v=%b %h exp 1 %h", ib.axis_out_tvalid,
                               ib.axis_out_tdata, 128'hA0000004_A0000003_A0000002_A0000001);
        end
        checks++;
        if ({ib.axis_out_tid, ib.axis_out_tdest, ib.axis_out_tlast} !== 7'b01_1000_1) begin
            errors++; $display("FAIL rmid_side got %b exp 0110001",
                               {ib.axis_out_tid, ib.axis_out_tdest, ib.axis_out_tlast});
        end
        repeat (2) tick();
        checks++;
        if (cred_b != 4) begin
            errors++; $display("FAIL rmid_credits got %0d exp 4", cred_b);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sf4_full();
        test_sf4_early();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
